// File: rtl/sale_pkg.sv
// Shared encodings for the vending-machine customer initiator: coin and drink
// codes on the machine interface, completion status and FSM state.
package sale_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN5     = 2'd1;
    localparam logic [1:0] COIN10    = 2'd2;

    localparam logic [1:0] DRINK_NONE = 2'd0;
    localparam logic [1:0] DRINK5     = 2'd1;
    localparam logic [1:0] DRINK10    = 2'd2;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_NO_FUNDS = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_MISMATCH = 2'd3
    } sale_status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COIN1 = 3'd1,
        S_COIN2 = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } sale_state_e;

endpackage

// File: rtl/sale_payer_plan.sv
// Combinational coin planner: from the drink choice and wallet contents decide
// which coins to pay with and what the machine should hand back.
module sale_payer_plan
    import sale_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             req_sel_i,
    input  logic [CNT_W-1:0] n5_i,
    input  logic [CNT_W-1:0] n10_i,
    output logic [1:0]       coin1_o,
    output logic             two_coin_o,
    output logic             funds_ok_o,
    output logic [1:0]       expect_drink_o,
    output logic             expect_change_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    always_comb begin
        coin1_o         = COIN_NONE;
        two_coin_o      = 1'b0;
        funds_ok_o      = 1'b0;
        expect_change_o = 1'b0;
        expect_drink_o  = req_sel_i ? DRINK10 : DRINK5;
        if (!req_sel_i) begin
            if (n5_i != CNT_ZERO) begin
                coin1_o    = COIN5;
                funds_ok_o = 1'b1;
            end else if (n10_i != CNT_ZERO) begin
                // Overpaying a 5$ drink with a 10$ coin earns one 5$ coin back.
                coin1_o         = COIN10;
                funds_ok_o      = 1'b1;
                expect_change_o = 1'b1;
            end
        end else begin
            if (n10_i != CNT_ZERO) begin
                coin1_o    = COIN10;
                funds_ok_o = 1'b1;
            end else if (n5_i >= CNT_TWO) begin
                coin1_o    = COIN5;
                two_coin_o = 1'b1;
                funds_ok_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sale_payer.sv
// Customer-side initiator: pays for a drink coin-by-coin on sel/din, checks the
// machine's drinks_out/change_out response and keeps the wallet up to date.
module sale_payer
    import sale_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_n5,
    input  logic [CNT_W-1:0] load_n10,
    input  logic             req,
    input  logic             req_sel,
    output logic             sel,
    output logic [1:0]       din,
    input  logic [1:0]       drinks_out,
    input  logic             change_out,
    output logic             ready,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] n5,
    output logic [CNT_W-1:0] n10,
    output sale_state_e      state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [3:0]       TIMER_LAST = 4'(TIMEOUT - 1);

    // Handshake: req/load are sampled only on a rising edge where ready=1;
    // load has priority. done is a single-cycle pulse and status is valid with it.

    sale_state_e      state_q;
    sale_status_e     status_q;
    logic             sel_q;
    logic [1:0]       din_q;
    logic             ready_q;
    logic             done_q;
    logic [CNT_W-1:0] n5_q;
    logic [CNT_W-1:0] n10_q;
    logic [3:0]       timer_q;
    logic             two_coin_q;
    logic [1:0]       exp_drink_q;
    logic             exp_change_q;

    logic [1:0]       plan_coin1;
    logic             plan_two_coin;
    logic             plan_funds_ok;
    logic [1:0]       plan_expect_drink;
    logic             plan_expect_change;
    logic [CNT_W-1:0] n5_refund_d;
    logic             resp_match;

    sale_payer_plan #(
        .CNT_W(CNT_W)
    ) u_plan (
        .req_sel_i      (req_sel),
        .n5_i           (n5_q),
        .n10_i          (n10_q),
        .coin1_o        (plan_coin1),
        .two_coin_o     (plan_two_coin),
        .funds_ok_o     (plan_funds_ok),
        .expect_drink_o (plan_expect_drink),
        .expect_change_o(plan_expect_change)
    );

    assign n5_refund_d = (n5_q == CNT_MAX) ? n5_q : n5_q + CNT_ONE;
    assign resp_match  = (drinks_out == exp_drink_q) && (change_out == exp_change_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            status_q     <= ST_OK;
            sel_q        <= 1'b0;
            din_q        <= COIN_NONE;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            n5_q         <= '0;
            n10_q        <= '0;
            timer_q      <= '0;
            two_coin_q   <= 1'b0;
            exp_drink_q  <= DRINK_NONE;
            exp_change_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        n5_q  <= load_n5;
                        n10_q <= load_n10;
                    end else if (req) begin
                        sel_q <= req_sel;
                        if (plan_funds_ok) begin
                            state_q      <= S_COIN1;
                            ready_q      <= 1'b0;
                            din_q        <= plan_coin1;
                            two_coin_q   <= plan_two_coin;
                            exp_drink_q  <= plan_expect_drink;
                            exp_change_q <= plan_expect_change;
                            // The first coin leaves the wallet as it goes on the bus.
                            if (plan_coin1 == COIN10) begin
                                n10_q <= n10_q - CNT_ONE;
                            end else begin
                                n5_q <= n5_q - CNT_ONE;
                            end
                        end else begin
                            done_q   <= 1'b1;
                            status_q <= ST_NO_FUNDS;
                        end
                    end
                end
                S_COIN1: begin
                    if (two_coin_q) begin
                        state_q <= S_COIN2;
                        din_q   <= COIN5;
                        n5_q    <= n5_q - CNT_ONE;
                    end else begin
                        state_q <= S_WAIT;
                        din_q   <= COIN_NONE;
                        timer_q <= '0;
                    end
                end
                S_COIN2: begin
                    state_q <= S_WAIT;
                    din_q   <= COIN_NONE;
                    timer_q <= '0;
                end
                S_WAIT: begin
                    if (drinks_out != DRINK_NONE) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        status_q <= resp_match ? ST_OK : ST_MISMATCH;
                        if (change_out) begin
                            n5_q <= n5_refund_d;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        status_q <= ST_TIMEOUT;
                    end else begin
                        timer_q <= timer_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    din_q   <= COIN_NONE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign din       = din_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign status    = status_q;
    assign n5        = n5_q;
    assign n10       = n10_q;
    assign state_dbg = state_q;

endmodule
